// File: rtl/timed_address_decoder.sv
// Handshaked one-hot address decoder: each accepted in-range address drives one select
// line for P_HoldCycles cycles. Range-error pulses are built in only with TIMED_ADDRDEC_ERROR_EN.
module timed_address_decoder #(
   parameter int P_Outputs    = 32,
   parameter int P_AddrWidth  = 8,
   parameter int P_Base       = 0,
   parameter int P_HoldCycles = 2
) (
   input  logic                   In_Clock,
   input  logic                   In_Reset,
   input  logic                   In_Enable,
   input  logic                   In_Valid,
   input  logic [P_AddrWidth-1:0] In_Address,
   output logic                   Out_Ready,
   output logic [P_Outputs-1:0]   Out_DecodedAddress,
   output logic                   Out_Error
);

   localparam int                     LP_CntW   = $clog2(P_HoldCycles + 1);
   localparam logic [P_AddrWidth:0]   LP_Lo     = (P_AddrWidth + 1)'(P_Base);
   localparam logic [P_AddrWidth:0]   LP_Hi     = (P_AddrWidth + 1)'(P_Base + P_Outputs);
   localparam logic [P_AddrWidth-1:0] LP_BaseA  = P_AddrWidth'(P_Base);
   localparam logic [LP_CntW-1:0]     LP_Reload = LP_CntW'(P_HoldCycles - 1);
   localparam logic [LP_CntW-1:0]     LP_One    = LP_CntW'(1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                 r_state;
   logic [LP_CntW-1:0]     r_cnt;
   logic [P_Outputs-1:0]   r_sel;

   logic                   w_ready;
   logic                   w_accept;
   logic                   w_above;
   logic                   w_below;
   logic                   w_in_range;
   logic [P_AddrWidth-1:0] w_index;
   logic [P_Outputs-1:0]   w_onehot;

   // Ready is forced low during reset so nothing can be accepted while it is asserted.
   assign w_ready   = (r_state == S_IDLE) & In_Enable & ~In_Reset;
   assign w_accept  = In_Valid & w_ready;
   assign Out_Ready = w_ready;

   generate
      if (P_Base == 0) begin : g_no_lower_bound
         assign w_above = 1'b1;
      end else begin : g_lower_bound
         assign w_above = ({1'b0, In_Address} >= LP_Lo);
      end
   endgenerate

   assign w_below    = ({1'b0, In_Address} < LP_Hi);
   assign w_in_range = w_above & w_below;
   assign w_index    = In_Address - LP_BaseA;

   always_comb begin
      w_onehot = '0;
      for (int k = 0; k < P_Outputs; k++) begin
         if (w_index == P_AddrWidth'(k)) begin
            w_onehot[k] = 1'b1;
         end
      end
   end

   // Leaving HOLD always passes through IDLE, which guarantees an all-zero cycle between selects.
   always_ff @(posedge In_Clock or posedge In_Reset) begin
      if (In_Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_in_range) begin
                  r_sel   <= w_onehot;
                  r_cnt   <= LP_Reload;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if ((r_cnt == '0) || !In_Enable) begin
                  r_sel   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - LP_One;
               end
            end
            default: begin
               r_sel   <= '0;
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Out_DecodedAddress = r_sel;

`ifdef TIMED_ADDRDEC_ERROR_EN
   logic r_error;

   always_ff @(posedge In_Clock or posedge In_Reset) begin
      if (In_Reset) begin
         r_error <= 1'b0;
      end else begin
         r_error <= w_accept & ~w_in_range;
      end
   end

   assign Out_Error = r_error;
`else
   assign Out_Error = 1'b0;
`endif

endmodule

// File: tb/tb_timed_address_decoder.sv
// Bench for timed_address_decoder (base 16, 8 lines, hold 3): vector table plus
// hand sequences for back-to-back, enable abort and asynchronous reset.
module tb_timed_address_decoder;

   localparam int AW   = 8;
   localparam int BASE = 16;
   localparam int NOUT = 8;
   localparam int HOLD = 3;
`ifdef TIMED_ADDRDEC_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            vld;
   logic [AW-1:0]   addr;
   logic            rdy;
   logic [NOUT-1:0] sel;
   logic            err;

   always #5 clk = ~clk;

   timed_address_decoder #(
      .P_Outputs   (NOUT),
      .P_AddrWidth (AW),
      .P_Base      (BASE),
      .P_HoldCycles(HOLD)
   ) dut (
      .In_Clock          (clk),
      .In_Reset          (rst),
      .In_Enable         (en),
      .In_Valid          (vld),
      .In_Address        (addr),
      .Out_Ready         (rdy),
      .Out_DecodedAddress(sel),
      .Out_Error         (err)
   );

   typedef struct {
      logic [NOUT-1:0] sel;
      logic            err;
      logic            rdy;
   } exp_t;

   typedef struct {
      logic [AW-1:0]   addr;
      logic [NOUT-1:0] sel;
      logic            in_range;
   } vec_t;

   exp_t q[$];
   vec_t vecs[7];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [NOUT-1:0] s, input logic e, input logic r);
      exp_t x;
      x.sel = s;
      x.err = e;
      x.rdy = r;
      q.push_back(x);
   endtask

   task automatic push_req(input logic [NOUT-1:0] s, input logic in_range);
      if (in_range) begin
         for (int i = 0; i < HOLD; i++) push(s, 1'b0, 1'b0);
      end else begin
         push('0, ERR_EN, 1'b1);
      end
      push('0, 1'b0, 1'b1);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      e = q.pop_front();
      check({tag, ".sel"}, 32'(sel), 32'(e.sel));
      check({tag, ".err"}, 32'(err), 32'(e.err));
      check({tag, ".rdy"}, 32'(rdy), 32'(e.rdy));
      check({tag, ".onehot"}, 32'($countones(sel) <= 1), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'd18,  8'h04, 1'b1};
      vecs[1] = '{8'd16,  8'h01, 1'b1};
      vecs[2] = '{8'd23,  8'h80, 1'b1};
      vecs[3] = '{8'd20,  8'h10, 1'b1};
      vecs[4] = '{8'd15,  8'h00, 1'b0};
      vecs[5] = '{8'd24,  8'h00, 1'b0};
      vecs[6] = '{8'd255, 8'h00, 1'b0};

      rst  = 1'b1;
      en   = 1'b1;
      vld  = 1'b0;
      addr = '0;
      #1;
      check("reset.sel", 32'(sel), 32'd0);
      check("reset.err", 32'(err), 32'd0);
      check("reset.rdy", 32'(rdy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("release.rdy", 32'(rdy), 32'd1);
      @(negedge clk);

      // Table: single requests from idle.
      for (int v = 0; v < 7; v++) begin
         vld  = 1'b1;
         addr = vecs[v].addr;
         #1;
         check($sformatf("vec%0d.accept_rdy", v), 32'(rdy), 32'd1);
         push_req(vecs[v].sel, vecs[v].in_range);
         @(posedge clk);
         #1;
         vld = 1'b0;
         while (q.size() > 0) begin
            @(negedge clk);
            pop_check($sformatf("vec%0d", v));
         end
      end

      // Back-to-back in-range with valid held high.
      vld  = 1'b1;
      addr = 8'd16;
      push_req(8'h01, 1'b1);
      push_req(8'h80, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pop_check($sformatf("b2b%0d", i));
         if (i == 0) addr = 8'd23;
         if (i == 4) vld = 1'b0;
      end

      // Back-to-back out-of-range: error pulses on consecutive cycles, ready stays high.
      vld  = 1'b1;
      addr = 8'd15;
      push('0, ERR_EN, 1'b1);
      push('0, ERR_EN, 1'b1);
      push('0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pop_check($sformatf("errb2b%0d", i));
         if (i == 0) addr = 8'd24;
         if (i == 1) vld = 1'b0;
      end

      // Enable drop during hold aborts the select at the next edge.
      vld  = 1'b1;
      addr = 8'd20;
      @(negedge clk);
      check("abort.c1.sel", 32'(sel), 32'h10);
      vld = 1'b0;
      @(negedge clk);
      check("abort.c2.sel", 32'(sel), 32'h10);
      en  = 1'b0;
      vld = 1'b1;
      #1;
      check("abort.rdy_low", 32'(rdy), 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("abort.off%0d.sel", i), 32'(sel), 32'd0);
         check($sformatf("abort.off%0d.rdy", i), 32'(rdy), 32'd0);
         check($sformatf("abort.off%0d.err", i), 32'(err), 32'd0);
      end
      vld = 1'b0;
      en  = 1'b1;
      #1;
      check("abort.rdy_back", 32'(rdy), 32'd1);
      @(negedge clk);
      check("abort.after.sel", 32'(sel), 32'd0);

      // Asynchronous reset in the second select cycle.
      vld  = 1'b1;
      addr = 8'd18;
      @(negedge clk);
      check("rst.c1.sel", 32'(sel), 32'h04);
      vld = 1'b0;
      @(negedge clk);
      check("rst.c2.sel", 32'(sel), 32'h04);
      #1 rst = 1'b1;
      #1;
      check("rst.async.sel", 32'(sel), 32'd0);
      check("rst.async.rdy", 32'(rdy), 32'd0);
      @(negedge clk);
      check("rst.held.sel", 32'(sel), 32'd0);
      check("rst.held.rdy", 32'(rdy), 32'd0);
      rst = 1'b0;
      #1;
      check("rst.rel.rdy", 32'(rdy), 32'd1);
      @(negedge clk);
      check("rst.rel.sel", 32'(sel), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
